pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32 pipeline. Consumes the registered `enable_bubble` from the load-use hazard unit, branch-resolution flushes from EX, and data-memory busy, and drives the write-enable/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It latches events that arrive during a memory freeze and replays them when the freeze ends, so no hazard is lost.

---
 rtl/pipeline_stall_controller_pkg.sv | 14 +
 rtl/pipeline_stall_controller_if.sv | 27 ++
 rtl/pipeline_stall_controller_perf_counters.sv | 27 ++
 rtl/pipeline_stall_controller.sv | 127 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline definitions: controller state encoding, NOP word and default memory-wait limit.
package pipeline_stall_controller_pkg;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   // addi x0, x0, 0 -- what the IF/ID and ID/EX flush consumers load
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam int WAIT_TIMEOUT_DEF = 255;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard requests in, per-stage load enables and flushes out.
interface pipeline_stall_controller_if;

   logic enable_bubble;
   logic branch_taken;
   logic dmem_busy;
   logic pc_write_en;
   logic ifid_write_en;
   logic ifid_flush;
   logic idex_flush;
   logic exmem_write_en;
   logic memwb_write_en;
   logic mem_timeout;

   modport master (
      input  enable_bubble, branch_taken, dmem_busy,
      output pc_write_en, ifid_write_en, ifid_flush, idex_flush,
             exmem_write_en, memwb_write_en, mem_timeout
   );

   modport slave (
      output enable_bubble, branch_taken, dmem_busy,
      input  pc_write_en, ifid_write_en, ifid_flush, idex_flush,
             exmem_write_en, memwb_write_en, mem_timeout
   );

endinterface

// File: rtl/pipeline_stall_controller_perf_counters.sv
// Stall, bubble and flush event counters; each wraps modulo 2^CNT_W.
module stall_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             bubble,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_count,
   output logic [CNT_W-1:0] flush_count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         bubble_count <= '0;
         flush_count  <= '0;
      end else begin
         if (stall)  stall_cycles <= stall_cycles + 1'b1;
         if (bubble) bubble_count <= bubble_count + 1'b1;
         if (flush)  flush_count  <= flush_count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline; replays hazards latched during a memory freeze.
// Define STALL_PERF_CNT_EN to add the stall/bubble/flush performance counters.
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF,
   parameter int CNT_W        = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   pipeline_stall_controller_if.master ctl
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]            stall_cycles,
   output logic [CNT_W-1:0]            bubble_count,
   output logic [CNT_W-1:0]            flush_count
`endif
);

   localparam logic [15:0] WAIT_LIM = 16'(WAIT_TIMEOUT);

   state_t      state;
   logic        pend_br;
   logic        pend_bub;
   logic [15:0] wait_cnt;
   logic        timeout;
   logic        br;
   logic        bub;
   logic        frozen;
   logic        pc_we;
   logic        ifid_we;
   logic        ifid_fl;
   logic        idex_fl;
   logic        late_we;

   assign br     = ctl.branch_taken | pend_br;
   assign bub    = ctl.enable_bubble | pend_bub;
   // The MEM_WAIT exit cycle stays frozen; pending events apply the cycle after.
   assign frozen = (state == ST_MEM_WAIT) | ctl.dmem_busy;

   always_comb begin
      pc_we   = 1'b1;
      ifid_we = 1'b1;
      ifid_fl = 1'b0;
      idex_fl = 1'b0;
      late_we = 1'b1;
      if (reset) begin
         pc_we = 1'b1;
      end else if (frozen) begin
         pc_we   = 1'b0;
         ifid_we = 1'b0;
         late_we = 1'b0;
      end else if (br) begin
         ifid_fl = 1'b1;
         idex_fl = 1'b1;
      end else if (bub) begin
         pc_we   = 1'b0;
         ifid_we = 1'b0;
         idex_fl = 1'b1;
      end
   end

   assign ctl.pc_write_en    = pc_we;
   assign ctl.ifid_write_en  = ifid_we;
   assign ctl.ifid_flush     = ifid_fl;
   assign ctl.idex_flush     = idex_fl;
   assign ctl.exmem_write_en = late_we;
   assign ctl.memwb_write_en = late_we;
   assign ctl.mem_timeout    = timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_RUN;
         pend_br  <= 1'b0;
         pend_bub <= 1'b0;
         wait_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (ctl.dmem_busy) begin
                  pend_br  <= pend_br | ctl.branch_taken;
                  pend_bub <= pend_bub | ctl.enable_bubble;
                  wait_cnt <= '0;
                  state    <= ST_MEM_WAIT;
               end else if (br) begin
                  // A bubble coincident with a flush belongs to the wrong path.
                  pend_br  <= 1'b0;
                  pend_bub <= 1'b0;
               end else if (bub) begin
                  pend_bub <= 1'b0;
               end
            end
            ST_MEM_WAIT: begin
               pend_br  <= pend_br | ctl.branch_taken;
               pend_bub <= pend_bub | ctl.enable_bubble;
               if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 16'd1;
               if (wait_cnt >= WAIT_LIM - 16'd1) timeout <= 1'b1;
               if (!ctl.dmem_busy) state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic bubble_issued;
   logic flush_issued;

   assign bubble_issued = !reset && !frozen && !br && bub;
   assign flush_issued  = !reset && !frozen && br;

   stall_perf_counters #(
      .CNT_W(CNT_W)
   ) u_perf (
      .clk         (clk),
      .reset       (reset),
      .stall       (!pc_we),
      .bubble      (bubble_issued),
      .flush       (flush_issued),
      .stall_cycles(stall_cycles),
      .bubble_count(bubble_count),
      .flush_count (flush_count)
   );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller (WAIT_TIMEOUT=4): per-cycle control vectors plus timeout flag.
module tb_pipeline_stall_controller;

   // Control vector order: {pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, memwb_we}
   localparam logic [5:0] RUNV = 6'b110011;
   localparam logic [5:0] BRV  = 6'b111111;
   localparam logic [5:0] BUBV = 6'b000111;
   localparam logic [5:0] FRZV = 6'b000000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_stall_controller_if bus ();

`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] bubble_count;
   logic [31:0] flush_count;
`endif

   pipeline_stall_controller #(
      .WAIT_TIMEOUT(4),
      .CNT_W       (32)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .ctl  (bus)
`ifdef STALL_PERF_CNT_EN
      ,
      .stall_cycles(stall_cycles),
      .bubble_count(bubble_count),
      .flush_count (flush_count)
`endif
   );

   int checks   = 0;
   int failures = 0;
   logic [6:0] sb[$];

   function automatic logic [6:0] observe();
      return {bus.mem_timeout, bus.pc_write_en, bus.ifid_write_en, bus.ifid_flush,
              bus.idex_flush, bus.exmem_write_en, bus.memwb_write_en};
   endfunction

   // Drive one cycle of stimulus and queue what the controller must show in that cycle.
   task automatic step(input logic br, input logic bub, input logic busy, input logic [6:0] exp);
      @(negedge clk);
      bus.branch_taken  = br;
      bus.enable_bubble = bub;
      bus.dmem_busy     = busy;
      sb.push_back(exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus.branch_taken  = 1'b0;
      bus.enable_bubble = 1'b0;
      bus.dmem_busy     = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] got, exp;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         reset = (i < 2);
         bus.branch_taken  = 1'b0;
         bus.enable_bubble = 1'b0;
         bus.dmem_busy     = 1'b0;
         sb.push_back({1'b0, RUNV});
         #1;
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset cycle %0d got=%b expected=%b", i, got, exp);
         end
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if ({stall_cycles, bubble_count, flush_count} !== 96'd0) begin
         failures++;
         $display("FAIL reset_counters got=%0d/%0d/%0d expected=0/0/0",
                  stall_cycles, bubble_count, flush_count);
      end
`endif
   endtask

   task automatic test_bubble();
      logic [9:0] t[2] = '{{3'b010, 1'b0, BUBV}, {3'b000, 1'b0, RUNV}};
      logic [6:0] got, exp;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         step(t[i][9], t[i][8], t[i][7], t[i][6:0]);
         #1;
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL bubble step %0d got=%b expected=%b", i, got, exp);
         end
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (bubble_count !== 32'd1 || stall_cycles !== 32'd1) begin
         failures++;
         $display("FAIL bubble_counters bubble=%0d stall=%0d expected 1/1", bubble_count, stall_cycles);
      end
`endif
   endtask

   task automatic test_branch_bubble();
      logic [9:0] t[3] = '{{3'b110, 1'b0, BRV}, {3'b000, 1'b0, RUNV}, {3'b000, 1'b0, RUNV}};
      logic [6:0] got, exp;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(t[i][9], t[i][8], t[i][7], t[i][6:0]);
         #1;
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL branch_bubble step %0d got=%b expected=%b", i, got, exp);
         end
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (bubble_count !== 32'd0 || flush_count !== 32'd1) begin
         failures++;
         $display("FAIL branch_bubble_counters bubble=%0d flush=%0d expected 0/1", bubble_count, flush_count);
      end
`endif
   endtask

   task automatic test_freeze_branch();
      logic [9:0] t[6] = '{{3'b001, 1'b0, FRZV}, {3'b101, 1'b0, FRZV}, {3'b001, 1'b0, FRZV},
                           {3'b000, 1'b0, FRZV}, {3'b000, 1'b0, BRV},  {3'b000, 1'b0, RUNV}};
      logic [6:0] got, exp;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(t[i][9], t[i][8], t[i][7], t[i][6:0]);
         #1;
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL freeze_branch step %0d got=%b expected=%b", i, got, exp);
         end
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (stall_cycles !== 32'd4 || flush_count !== 32'd1) begin
         failures++;
         $display("FAIL freeze_counters stall=%0d flush=%0d expected 4/1", stall_cycles, flush_count);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [9:0] t[10] = '{{3'b010, 1'b0, BUBV}, {3'b010, 1'b0, BUBV}, {3'b000, 1'b0, RUNV},
                            {3'b100, 1'b0, BRV},  {3'b100, 1'b0, BRV},  {3'b000, 1'b0, RUNV},
                            {3'b011, 1'b0, FRZV}, {3'b000, 1'b0, FRZV}, {3'b000, 1'b0, BUBV},
                            {3'b000, 1'b0, RUNV}};
      logic [6:0] got, exp;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(t[i][9], t[i][8], t[i][7], t[i][6:0]);
         #1;
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL back_to_back step %0d got=%b expected=%b", i, got, exp);
         end
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (bubble_count !== 32'd3 || flush_count !== 32'd2) begin
         failures++;
         $display("FAIL back_to_back_counters bubble=%0d flush=%0d expected 3/2", bubble_count, flush_count);
      end
`endif
   endtask

   task automatic test_timeout();
      logic [9:0] t[9] = '{{3'b001, 1'b0, FRZV}, {3'b001, 1'b0, FRZV}, {3'b001, 1'b0, FRZV},
                           {3'b001, 1'b0, FRZV}, {3'b001, 1'b0, FRZV}, {3'b001, 1'b1, FRZV},
                           {3'b000, 1'b1, FRZV}, {3'b000, 1'b1, RUNV}, {3'b000, 1'b1, RUNV}};
      logic [6:0] got, exp;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step(t[i][9], t[i][8], t[i][7], t[i][6:0]);
         #1;
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL timeout step %0d got=%b expected=%b", i, got, exp);
         end
      end
   endtask

   task automatic test_reset_in_wait();
      logic [6:0] got, exp;
      do_reset();
      step(1'b0, 1'b0, 1'b1, {1'b0, FRZV});
      #1;
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL reset_in_wait enter got=%b expected=%b", got, exp);
      end
      step(1'b0, 1'b1, 1'b1, {1'b0, FRZV});
      #1;
      exp = sb.pop_front();
      got = observe();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL reset_in_wait latch got=%b expected=%b", got, exp);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         reset = (i < 2);
         bus.enable_bubble = 1'b0;
         bus.branch_taken  = 1'b0;
         bus.dmem_busy     = (i < 2);
         sb.push_back({1'b0, RUNV});
         #1;
         exp = sb.pop_front();
         got = observe();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL reset_in_wait after cycle %0d got=%b expected=%b", i, got, exp);
         end
      end
`ifdef STALL_PERF_CNT_EN
      checks++;
      if (bubble_count !== 32'd0) begin
         failures++;
         $display("FAIL reset_in_wait_bubble_count got=%0d expected=0", bubble_count);
      end
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset             = 1'b1;
      bus.branch_taken  = 1'b0;
      bus.enable_bubble = 1'b0;
      bus.dmem_busy     = 1'b0;
      test_reset();
      test_bubble();
      test_branch_bubble();
      test_freeze_branch();
      test_back_to_back();
      test_timeout();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
